// File: rtl/noc_pkg.sv
// Router-wide constants and types shared by the NoC blocks.
package noc_pkg;

  localparam int unsigned PORT_NUM = 5;
  localparam int unsigned VC_NUM   = 4;
  localparam int unsigned VC_SIZE  = $clog2(VC_NUM);
  localparam int unsigned PORT_W   = $clog2(PORT_NUM);
  localparam int unsigned SA_CNT_W = 16;

  typedef logic [PORT_W-1:0] port_t;

endpackage

// File: rtl/switch_allocator_pkg.sv
// Helpers local to the switch allocator and its round-robin arbiters.
package switch_allocator_pkg;

  // Modulo-n increment used for round-robin pointer advance.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant/crossbar bundle between the input block, allocator and crossbar.
// SA_GRANT_CNT_EN adds the per-output grant counters.
interface switch_allocator_if #(
  parameter int unsigned PORT_NUM = noc_pkg::PORT_NUM,
  parameter int unsigned VC_NUM   = noc_pkg::VC_NUM,
  parameter int unsigned VC_SIZE  = noc_pkg::VC_SIZE
);

  logic           [PORT_NUM-1:0][VC_NUM-1:0]              switch_request_i;
  noc_pkg::port_t [PORT_NUM-1:0][VC_NUM-1:0]              out_port_i;
  logic           [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] downstream_vc_i;
  logic           [PORT_NUM-1:0][VC_NUM-1:0]              on_off_i;
  logic           [PORT_NUM-1:0]                          valid_sel_o;
  logic           [PORT_NUM-1:0][VC_SIZE-1:0]             vc_sel_o;
  noc_pkg::port_t [PORT_NUM-1:0]                          xb_sel_o;
  logic           [PORT_NUM-1:0]                          xb_valid_o;
`ifdef SA_GRANT_CNT_EN
  logic [PORT_NUM-1:0][noc_pkg::SA_CNT_W-1:0]             grant_cnt_o;
`endif

  modport master (
`ifdef SA_GRANT_CNT_EN
    input  grant_cnt_o,
`endif
    output switch_request_i, out_port_i, downstream_vc_i, on_off_i,
    input  valid_sel_o, vc_sel_o, xb_sel_o, xb_valid_o
  );

  modport slave (
`ifdef SA_GRANT_CNT_EN
    output grant_cnt_o,
`endif
    input  switch_request_i, out_port_i, downstream_vc_i, on_off_i,
    output valid_sel_o, vc_sel_o, xb_sel_o, xb_valid_o
  );

endinterface

// File: rtl/switch_allocator_round_robin_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; the pointer
// moves past the winner only when the caller confirms the grant.
module round_robin_arbiter
  import switch_allocator_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_i,
  input  logic            update_en_i,
  output logic [N-1:0]    grant_o,
  output logic [IdxW-1:0] idx_o
);

  logic [IdxW-1:0] ptr_q;
  logic            found;
  int unsigned     cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = 32'(ptr_q) + off;
      if (cand >= N) cand = cand - N;
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = IdxW'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (update_en_i && found) begin
      ptr_q <= IdxW'(wrap_inc(32'(idx_o), N));
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Separable input-first round-robin switch allocator with registered crossbar select.
// SA_GRANT_CNT_EN adds saturating per-output grant counters on grant_cnt_o.
module switch_allocator
  import switch_allocator_pkg::*;
#(
  parameter int unsigned PORT_NUM = noc_pkg::PORT_NUM,
  parameter int unsigned VC_NUM   = noc_pkg::VC_NUM,
  parameter int unsigned VC_SIZE  = noc_pkg::VC_SIZE
) (
  input logic               clk,
  input logic               rst,
  switch_allocator_if.slave bus
);

  logic           [PORT_NUM-1:0][VC_NUM-1:0]   eligible;
  logic           [PORT_NUM-1:0][VC_NUM-1:0]   cand_oh;
  logic           [PORT_NUM-1:0][VC_SIZE-1:0]  cand_vc;
  logic           [PORT_NUM-1:0]               has_cand;
  noc_pkg::port_t [PORT_NUM-1:0]               target;
  logic           [PORT_NUM-1:0][PORT_NUM-1:0] out_req;  // [op][ip]
  logic           [PORT_NUM-1:0][PORT_NUM-1:0] out_gnt;  // [op][ip]
  noc_pkg::port_t [PORT_NUM-1:0]               out_idx;
  logic           [PORT_NUM-1:0]               out_busy;
  logic           [PORT_NUM-1:0]               in_won;
  logic           [PORT_NUM-1:0]               xb_valid_q;
  noc_pkg::port_t [PORT_NUM-1:0]               xb_sel_q;

  // Out-of-range ports are dropped before on_off_i is indexed.
  always_comb begin
    eligible = '0;
    for (int unsigned ip = 0; ip < PORT_NUM; ip++) begin
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        if (bus.switch_request_i[ip][v] && (32'(bus.out_port_i[ip][v]) < PORT_NUM)) begin
          eligible[ip][v] = bus.on_off_i[bus.out_port_i[ip][v]][bus.downstream_vc_i[ip][v]];
        end
      end
    end
  end

  for (genvar ip = 0; ip < PORT_NUM; ip++) begin : g_in_arb
    round_robin_arbiter #(
      .N (VC_NUM)
    ) u_in_arb (
      .clk         (clk),
      .rst         (rst),
      .req_i       (eligible[ip]),
      .update_en_i (in_won[ip]),
      .grant_o     (cand_oh[ip]),
      .idx_o       (cand_vc[ip])
    );
  end

  always_comb begin
    out_req = '0;
    for (int unsigned ip = 0; ip < PORT_NUM; ip++) begin
      has_cand[ip] = |cand_oh[ip];
      target[ip]   = bus.out_port_i[ip][cand_vc[ip]];
      for (int unsigned op = 0; op < PORT_NUM; op++) begin
        out_req[op][ip] = has_cand[ip] && (target[ip] == noc_pkg::port_t'(op));
      end
    end
  end

  for (genvar op = 0; op < PORT_NUM; op++) begin : g_out_arb
    round_robin_arbiter #(
      .N (PORT_NUM)
    ) u_out_arb (
      .clk         (clk),
      .rst         (rst),
      .req_i       (out_req[op]),
      .update_en_i (1'b1),
      .grant_o     (out_gnt[op]),
      .idx_o       (out_idx[op])
    );
  end

  always_comb begin
    in_won   = '0;
    out_busy = '0;
    for (int unsigned op = 0; op < PORT_NUM; op++) begin
      out_busy[op] = |out_gnt[op];
      in_won       = in_won | out_gnt[op];
    end
  end

  always_comb begin
    bus.valid_sel_o = rst ? in_won : '0;
    for (int unsigned ip = 0; ip < PORT_NUM; ip++) begin
      bus.vc_sel_o[ip] = (rst && in_won[ip]) ? cand_vc[ip] : '0;
    end
  end

  // Crossbar select lines up with the input port's registered flit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      xb_valid_q <= '0;
      xb_sel_q   <= '0;
    end else begin
      xb_valid_q <= out_busy;
      for (int unsigned op = 0; op < PORT_NUM; op++) begin
        if (out_busy[op]) xb_sel_q[op] <= out_idx[op];
      end
    end
  end

  assign bus.xb_valid_o = xb_valid_q;
  assign bus.xb_sel_o   = xb_sel_q;

`ifdef SA_GRANT_CNT_EN
  logic [PORT_NUM-1:0][noc_pkg::SA_CNT_W-1:0] grant_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      grant_cnt_q <= '0;
    end else begin
      for (int unsigned op = 0; op < PORT_NUM; op++) begin
        if (xb_valid_q[op] && (grant_cnt_q[op] != '1)) grant_cnt_q[op] <= grant_cnt_q[op] + 1'b1;
      end
    end
  end

  assign bus.grant_cnt_o = grant_cnt_q;
`endif

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Separable input-first round-robin switch allocator. Sits directly downstream of the router's input block.
- Consumes per-VC switch requests, the computed output port and the allocated downstream VC from every input port. Masks these with the downstream on/off flow-control state.
- Returns at most one VC grant per input port, with at most one input per output port.
- Drives the registered crossbar select and flit-valid toward the output links.

Parameters:
- PORT_NUM, 5, number of router ports (inputs = outputs).
- VC_NUM, noc_pkg VC_NUM, virtual channels per port.
- VC_SIZE, $clog2(VC_NUM), VC index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active low.
- switch_request_i  in  PORT_NUM x VC_NUM  per input port/VC: head-of-buffer flit wants the switch (VC already allocated).
- out_port_i  in  PORT_NUM x VC_NUM x port_t  output port computed for each input VC.
- downstream_vc_i  in  PORT_NUM x VC_NUM x VC_SIZE  downstream VC allocated to each input VC.
- on_off_i  in  PORT_NUM x VC_NUM  per output port: downstream VC may accept flits (1 = on).
- valid_sel_o  out  PORT_NUM  input port ip granted this cycle.
- vc_sel_o  out  PORT_NUM x VC_SIZE  granted VC index at input port ip.
- xb_sel_o  out  PORT_NUM x port_t  registered: input port routed to output op.
- xb_valid_o  out  PORT_NUM  registered: output op carries a valid flit.

Behaviour:
- Eligibility: VC v of input ip is eligible when all of the following hold:
  - switch_request_i[ip][v] = 1;
  - out_port_i[ip][v] < PORT_NUM;
  - on_off_i[out_port_i[ip][v]][downstream_vc_i[ip][v]] = 1.
- Requests naming an out-of-range port are ignored.
- Stage 1, per input: round-robin over eligible VCs, starting from in_ptr[ip]. Yields candidate VC c[ip] and target t[ip].
- Stage 2, per output: round-robin over inputs whose t = op, starting from out_ptr[op].
- Grant outputs are combinational, in the same cycle as the requests:
  - valid_sel_o[ip] = 1 iff ip wins stage 2;
  - vc_sel_o[ip] = c[ip] when granted, else 0.
- Pointer update, on the clk edge, only for winning pairs:
  - in_ptr[ip] <= (c[ip]+1) mod VC_NUM;
  - out_ptr[op] <= (ip+1) mod PORT_NUM.
  - Losers and idle arbiters hold their pointers. This guarantees no starvation.
- Crossbar outputs: registered one cycle after the grant, aligned with the input port's registered flit output.
  - xb_valid_o[op] <= 1 if some input won op, else 0.
  - xb_sel_o[op] <= the winning ip; it holds its previous value when the output is idle.
- Invariants:
  - At most one grant per input and one per output each cycle.
  - A granted VC always has its downstream VC on.
- on_off_i dropping in the same cycle as a request masks that request in that cycle; no grant is issued.
- Wrap-around: a pointer at VC_NUM-1 or PORT_NUM-1 advances to 0.
- Reset (rst = 0, sampled at clk):
  - all pointers go to 0;
  - xb_valid_o and xb_sel_o go to 0;
  - valid_sel_o and vc_sel_o are forced to 0 combinationally while rst = 0.
- Reset mid-operation discards any pending crossbar transfer; the next cycle has xb_valid_o = 0.
- No requests: all grants are 0, pointers hold, xb_valid_o = 0 on the next edge.

Optional Feature:
- Macro: SA_GRANT_CNT_EN.
- Defined: adds output grant_cnt_o (PORT_NUM x 16).
  - Per-output saturating counter, incremented on each xb_valid_o assertion.
  - Cleared by reset; holds at 16'hFFFF.
- Undefined: port and counters are absent; all other behaviour is identical.

Decomposition:
- noc_pkg carries PORT_NUM, VC_NUM, VC_SIZE and port_t (existing). Add the constant SA_CNT_W = 16.
- Sub-module round_robin_arbiter #(N):
  - inputs: request vector and update enable;
  - outputs: one-hot grant and index;
  - internal registered pointer.
- Instances: PORT_NUM with N = VC_NUM for stage 1, and PORT_NUM with N = PORT_NUM for stage 2.

Test Plan:
1. Reset, then input 0 VC 1 requests with out_port 2, downstream VC 0, on -> same cycle valid_sel_o[0] = 1, vc_sel_o[0] = 1. Next cycle xb_valid_o[2] = 1, xb_sel_o[2] = 0.
2. Inputs 0, 1, 3 all request output 4 continuously, all on -> grants rotate 0, 1, 3, 0, ... with exactly one valid_sel_o per cycle.
3. Input 2 requests on all VCs to distinct outputs, all on -> vc_sel_o[2] cycles 0, 1, 2, 3, 0.
4. Set on_off_i[1][3] = 0 while input 0 requests output 1, downstream VC 3 -> no grant; restoring on gives a grant that same cycle.
5. Pull rst low during a continuous grant stream -> valid_sel_o = 0 immediately. After release, the first grant goes to the lowest-index requester (pointers back at 0).
6. With SA_GRANT_CNT_EN defined, run 70000 grants to output 0 -> grant_cnt_o[0] saturates at 16'hFFFF.
